pc_trace_buffer: RTL and testbench

PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

---
 rtl/pc_trace_buffer_if.sv | 10 +
 rtl/pc_trace_buffer.sv | 137 +++++++++++++
 tb/tb_pc_trace_buffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_trace_buffer_if.sv
// Downstream trace stream: one 32-bit word per handshake, tagged PC or ALU.
interface pc_trace_buffer_if;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trace_sel;
  logic        trace_ready;

  modport master (output trace_valid, output trace_data, output trace_sel, input trace_ready);
  modport slave  (input trace_valid, input trace_data, input trace_sel, output trace_ready);
endinterface

// File: rtl/pc_trace_buffer.sv
// PC/ALU trace buffer: captures {PC, ALU} pairs into a FIFO and serializes
// each pair as two words (PC then ALU) onto a valid/ready stream.
// Capture never stalls; when the FIFO is full and nothing leaves, the
// capture is dropped and accounted in overflow/drop_count.
module pc_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              PCValue,
  input  logic [31:0]              ALUResult,
  input  logic                     capture_en,
  input  logic                     clear_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  pc_trace_buffer_if.master        trace
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_PC, SEND_ALU} state_t;

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [31:0]   holdPc, holdAlu;
  logic [63:0]   head;
  logic          doPop, doPush, doDrop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  // Pop feeds the output stage: from IDLE, or back-to-back after the ALU word is taken.
  assign doPop  = !empty && ((state == IDLE) || (state == SEND_ALU && trace.trace_ready));
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign doPush = capture_en && (!full || doPop);
  assign doDrop = capture_en && !doPush;

  // Storage array, not reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= {PCValue, ALUResult};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drop accounting; clear takes effect before a coincident drop is counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_ovf) begin
      overflow   <= doDrop;
      drop_count <= doDrop ? 16'd1 : 16'd0;
    end else if (doDrop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  // Output FSM with registered stream outputs; words hold while not accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      holdPc            <= '0;
      holdAlu           <= '0;
      trace.trace_valid <= 1'b0;
      trace.trace_data  <= '0;
      trace.trace_sel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (doPop) begin
            holdPc            <= head[63:32];
            holdAlu           <= head[31:0];
            state             <= SEND_PC;
            trace.trace_valid <= 1'b1;
            trace.trace_data  <= head[63:32];
            trace.trace_sel   <= 1'b0;
          end else begin
            trace.trace_valid <= 1'b0;
            trace.trace_data  <= '0;
            trace.trace_sel   <= 1'b0;
          end
        end
        SEND_PC: begin
          if (trace.trace_ready) begin
            state            <= SEND_ALU;
            trace.trace_data <= holdAlu;
            trace.trace_sel  <= 1'b1;
          end
        end
        SEND_ALU: begin
          if (trace.trace_ready) begin
            if (doPop) begin
              holdPc            <= head[63:32];
              holdAlu           <= head[31:0];
              state             <= SEND_PC;
              trace.trace_valid <= 1'b1;
              trace.trace_data  <= head[63:32];
              trace.trace_sel   <= 1'b0;
            end else begin
              state             <= IDLE;
              trace.trace_valid <= 1'b0;
              trace.trace_data  <= '0;
              trace.trace_sel   <= 1'b0;
            end
          end
        end
        default: begin
          state             <= IDLE;
          trace.trace_valid <= 1'b0;
          trace.trace_data  <= '0;
          trace.trace_sel   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pc_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PCValue = '0, ALUResult = '0;
  logic        capture_en = 1'b0, clear_ovf = 1'b0;
  logic        full, empty, overflow;
  logic [4:0]  count;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  pc_trace_buffer_if tif();

  pc_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PCValue(PCValue), .ALUResult(ALUResult),
    .capture_en(capture_en), .clear_ovf(clear_ovf), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .drop_count(drop_count), .trace(tif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending pairs plus the pair being sent.
  logic [63:0] mq[$];
  logic [31:0] mPc, mAlu;
  int          mPh;        // 0 nothing shown, 1 showing PC, 2 showing ALU
  logic        mOvf;
  logic [15:0] mDrop;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete(); mPh = 0; mPc = 0; mAlu = 0; mOvf = 0; mDrop = 0;
      end else begin
        bit pop, push, drop;
        pop  = (mq.size() != 0) && (mPh == 0 || (mPh == 2 && tif.trace_ready));
        push = capture_en && (mq.size() < DEPTH || pop);
        drop = capture_en && !push;
        if (clear_ovf) begin
          mOvf = drop; mDrop = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
          mOvf = 1'b1;
          if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
        end
        if (mPh == 1 && tif.trace_ready) mPh = 2;
        else if (mPh == 2 && tif.trace_ready) mPh = 0;
        if (pop) begin {mPc, mAlu} = mq.pop_front(); mPh = 1; end
        if (push) mq.push_back({PCValue, ALUResult});
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_valid", tif.trace_valid, mPh != 0);
    chk("m_data",  tif.trace_data, (mPh == 1) ? mPc : (mPh == 2) ? mAlu : 32'h0);
    chk("m_sel",   tif.trace_sel, mPh == 2);
    chk("m_count", count, mq.size());
    chk("m_empty", empty, mq.size() == 0);
    chk("m_full",  full, mq.size() == DEPTH);
    chk("m_ovf",   overflow, mOvf);
    chk("m_drop",  drop_count, mDrop);
  end

  // Words accepted downstream, for stream-integrity checks.
  logic [31:0] acc[$];
  always @(posedge clk)
    if (reset && tif.trace_valid && tif.trace_ready) acc.push_back(tif.trace_data);

  task automatic drain(input int maxc);
    int n = 0;
    tif.trace_ready = 1'b1;
    while ((tif.trace_valid || !empty) && n < maxc) begin
      @(negedge clk); n++;
    end
    chk("drain_done", n < maxc, 1'b1);
  endtask

  initial begin
    tif.trace_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", tif.trace_valid, 0);
    chk("rst_data", tif.trace_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single pair, consumer always ready
    PCValue = 32'h0040_0000; ALUResult = 32'h5; capture_en = 1'b1; tif.trace_ready = 1'b1;
    @(negedge clk); capture_en = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_idle", tif.trace_valid, 0);
    @(negedge clk);
    chk("t1_pc", tif.trace_data, 32'h0040_0000);
    chk("t1_pcsel", tif.trace_sel, 0);
    chk("t1_pcvalid", tif.trace_valid, 1);
    @(negedge clk);
    chk("t1_alu", tif.trace_data, 32'h5);
    chk("t1_alusel", tif.trace_sel, 1);
    @(negedge clk);
    chk("t1_end_valid", tif.trace_valid, 0);
    chk("t1_end_empty", empty, 1);

    // Overfill with consumer stalled, then drain in order
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      PCValue = 32'h0040_0000 + 32'(4 * i); ALUResult = 32'(i); capture_en = 1'b1;
      @(negedge clk);
    end
    capture_en = 1'b0;
    chk("t2_full", full, 1);
    chk("t2_count", count, 16);
    chk("t2_ovf", overflow, 1);
    chk("t2_drop", drop_count, 3);
    tif.trace_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("t2_pc", tif.trace_data, 32'h0040_0000 + 32'(4 * k));
      chk("t2_pcsel", tif.trace_sel, 0);
      @(negedge clk);
      chk("t2_alu", tif.trace_data, 32'(k));
      @(negedge clk);
    end
    chk("t2_idle", tif.trace_valid, 0);
    chk("t2_empty", empty, 1);
    clear_ovf = 1'b1; @(negedge clk); clear_ovf = 1'b0;
    chk("t2_clr_ovf", overflow, 0);
    chk("t2_clr_drop", drop_count, 0);

    // Capture at the consumer's rate: no bubbles, no overflow
    for (int i = 0; i < 20; i++) begin
      capture_en = (i % 2 == 0); PCValue = 32'h2000 + 32'(4 * i); ALUResult = 32'(100 + i);
      @(negedge clk);
      if (i >= 1) chk("t3_nobubble", tif.trace_valid, 1);
      chk("t3_cnt_le1", count <= 1, 1);
    end
    capture_en = 1'b0;
    chk("t3_ovf", overflow, 0);
    drain(20);

    // Toggling ready: every word exactly once, in order
    acc.delete();
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PCValue = 32'h100 + 32'(4 * i); ALUResult = 32'hA0 + 32'(i); capture_en = 1'b1;
      @(negedge clk);
    end
    capture_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tif.trace_ready = c[0];
      @(negedge clk);
    end
    drain(20);
    chk("t4_nwords", acc.size(), 6);
    if (acc.size() == 6) begin
      chk("t4_w0", acc[0], 32'h100); chk("t4_w1", acc[1], 32'hA0);
      chk("t4_w2", acc[2], 32'h104); chk("t4_w3", acc[3], 32'hA1);
      chk("t4_w4", acc[4], 32'h108); chk("t4_w5", acc[5], 32'hA2);
    end

    // Reset mid-transfer in SEND_ALU with 5 queued
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      PCValue = 32'h300 + 32'(4 * i); ALUResult = 32'(i); capture_en = 1'b1;
      @(negedge clk);
    end
    capture_en = 1'b0;
    chk("t5_count5", count, 5);
    tif.trace_ready = 1'b1; @(negedge clk); tif.trace_ready = 1'b0;
    chk("t5_in_alu", tif.trace_sel, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", tif.trace_valid, 0);
    chk("t5_rst_data", tif.trace_data, 0);
    chk("t5_rst_count", count, 0);
    @(negedge clk); reset = 1'b1;
    PCValue = 32'h10; ALUResult = 32'h11; capture_en = 1'b1; tif.trace_ready = 1'b1;
    @(negedge clk); capture_en = 1'b0;
    begin
      int n = 0;
      while (!tif.trace_valid && n < 5) begin @(negedge clk); n++; end
      chk("t5_wait", n < 5, 1);
    end
    chk("t5_first", tif.trace_data, 32'h10);
    drain(10);

    // clear_ovf coincident with a drop, then alone
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      PCValue = 32'h500 + 32'(4 * i); ALUResult = 32'(i); capture_en = 1'b1;
      @(negedge clk);
    end
    chk("t6_drop1", drop_count, 1);
    clear_ovf = 1'b1; @(negedge clk);
    chk("t6_both_ovf", overflow, 1);
    chk("t6_both_drop", drop_count, 1);
    capture_en = 1'b0; @(negedge clk); clear_ovf = 1'b0;
    chk("t6_clr_ovf", overflow, 0);
    chk("t6_clr_drop", drop_count, 0);
    drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
